seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
//  Moore-style serial bit-pattern generator: the transmit side of the FSM sequence-detector flow.
//  On a start request it captures a PAT_W-bit pattern and shifts it out MSB first, repeat_cnt times,
//  with gap_cycles of idle line between frames. Drives data_in of the sequence-detector blocks.
//  Also serves as a self-checking stimulus source for them.
// PARAMETERS
//  PAT_W  4  pattern width in bits, >=2
//  CNT_W  4  width of repeat_cnt
//  GAP_W  3  width of gap_cycles
// PORTS
//  clk         in   1      rising-edge clock; the only clock domain
//  rst         in   1      synchronous, active-high reset
//  start       in   1      request; sampled only in IDLE
//  pattern     in   PAT_W  bits to send; bit PAT_W-1 is sent first
//  repeat_cnt  in   CNT_W  number of frames; 0 = send nothing
//  gap_cycles  in   GAP_W  idle cycles between frames; 0 = back-to-back
//  data_out    out  1      serial bit; 0 whenever data_valid=0
//  data_valid  out  1      data_out carries a pattern bit this cycle
//  busy        out  1      high in SHIFT, GAP and DONE
//  done        out  1      one-cycle pulse after the last frame completes
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE. data_out, data_valid, busy and done are all 0. All counters clear.
//  Reset mid-operation aborts at once: no done pulse, and no further valid bits after that edge.
//  All outputs are registered and decoded from state only (Moore). No combinational input->output path.
//  States:
//   IDLE:  start=1 at edge N captures pattern, repeat_cnt and gap_cycles into internal registers.
//          If repeat_cnt!=0 -> SHIFT, with bit PAT_W-1 driven on data_out after edge N.
//          If repeat_cnt==0 -> DONE.
//   SHIFT: data_valid=1 for exactly PAT_W cycles per frame, MSB first. The bit counter wraps at PAT_W-1.
//          After the last bit: if frames remain and gap!=0 -> GAP.
//          If frames remain and gap==0 -> stay in SHIFT and reload the shift register from the captured
//          pattern (no bubble).
//          If no frames remain -> DONE.
//   GAP:   data_valid=0 and data_out=0 for exactly gap_cycles cycles, then -> SHIFT (new frame).
//   DONE:  done=1 and busy=1 for one cycle, then -> IDLE.
//  Latency: the first valid bit appears one cycle after start is sampled. The done pulse falls in the
//   cycle after the last valid bit.
//  Total valid cycles = PAT_W*repeat_cnt. Total gap cycles = gap_cycles*(repeat_cnt-1).
//  start while busy=1 is ignored; captured values are not disturbed.
//  The pattern, repeat_cnt and gap_cycles inputs may change freely after capture.
//  start held high through DONE->IDLE: a new run begins at the first edge where the state is IDLE.
//   This gives exactly one idle cycle between back-to-back runs.
//  repeat_cnt at its maximum (2^CNT_W-1) runs every frame. The frame counter never wraps.
// TESTING
//  T1: pattern=4'b0110, rep=1, gap=0, start pulse -> data_out 0,1,1,0 with valid=1 for 4 cycles;
//      done=1 on the 5th cycle; busy low on the 6th.
//  T2: 0110, rep=3, gap=0 -> 12 consecutive valid bits 011001100110, no valid gap; a chained 0110
//      detector asserts 3 times.
//  T3: 0110, rep=2, gap=2 -> valid bits 0110, then 2 cycles of valid=0/data_out=0, then 0110;
//      done follows the second frame.
//  T4: rep=0, start -> valid never asserts; done=1 exactly one cycle after start is sampled; busy=1
//      only in that cycle.
//  T5: start pulses during SHIFT with pattern=4'b1111 -> the original frame is emitted unchanged;
//      no extra frames.
//  T6: rst=1 after the 2nd bit of rep=3 -> from the next edge, all outputs are 0, state is IDLE and
//      no done pulse occurs; a new start then runs normally.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: Moore serial bit-pattern generator.
// On start (sampled only when idle) it captures pattern, repeat_cnt and gap_cycles, then shifts
// the pattern out MSB first repeat_cnt times, with gap_cycles idle cycles between frames. A
// one-cycle done pulse follows the last frame.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       run request, ignored while busy
//   pattern     PAT_W bits to send, MSB first
//   repeat_cnt  number of frames (0 = none, straight to done)
//   gap_cycles  idle cycles between frames (0 = back-to-back)
//   data_out    serial bit, 0 whenever data_valid is 0
//   data_valid  data_out carries a pattern bit
//   busy        high while shifting, in a gap, or signalling done
//   done        one-cycle completion pulse
module seq_pattern_gen #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned CNT_W = 4,
   parameter int unsigned GAP_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap_cycles,
   output logic             data_out,
   output logic             data_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BIT_W = $clog2(PAT_W);

   typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;      // captured pattern, reloaded per frame
   logic [PAT_W-1:0]   sh_q, sh_d;        // shift register, MSB is the current bit
   logic [BIT_W-1:0]   bit_q, bit_d;      // bit position within the frame
   logic [CNT_W-1:0]   frm_q, frm_d;      // frames remaining including the current one
   logic [GAP_W-1:0]   gap_q, gap_d;      // captured gap length
   logic [GAP_W-1:0]   gcnt_q, gcnt_d;    // gap cycles remaining including the current one

   logic               data_out_q, data_out_d;
   logic               data_valid_q, data_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      frm_d   = frm_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               pat_d = pattern;
               sh_d  = pattern;
               gap_d = gap_cycles;
               frm_d = repeat_cnt;
               bit_d = '0;
               state_d = (repeat_cnt != '0) ? StShift : StDone;
            end
         end
         StShift: begin
            if (bit_q == BIT_W'(PAT_W - 1)) begin
               // End of frame; frm_q >= 1 here so the decrement never wraps.
               frm_d = frm_q - CNT_W'(1);
               bit_d = '0;
               if (frm_q > CNT_W'(1)) begin
                  if (gap_q != '0) begin
                     gcnt_d  = gap_q;
                     state_d = StGap;
                  end else begin
                     sh_d = pat_q;
                  end
               end else begin
                  state_d = StDone;
               end
            end else begin
               sh_d  = sh_q << 1;
               bit_d = bit_q + BIT_W'(1);
            end
         end
         StGap: begin
            if (gcnt_q == GAP_W'(1)) begin
               sh_d    = pat_q;
               bit_d   = '0;
               state_d = StShift;
            end else begin
               gcnt_d = gcnt_q - GAP_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are registered copies decoded from the next state so they line up with state_q.
   always_comb begin
      data_valid_d = (state_d == StShift);
      data_out_d   = (state_d == StShift) ? sh_d[PAT_W-1] : 1'b0;
      busy_d       = (state_d != StIdle);
      done_d       = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         pat_q        <= '0;
         sh_q         <= '0;
         bit_q        <= '0;
         frm_q        <= '0;
         gap_q        <= '0;
         gcnt_q       <= '0;
         data_out_q   <= 1'b0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pat_q        <= pat_d;
         sh_q         <= sh_d;
         bit_q        <= bit_d;
         frm_q        <= frm_d;
         gap_q        <= gap_d;
         gcnt_q       <= gcnt_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed bench for seq_pattern_gen (PAT_W=4, CNT_W=4, GAP_W=3).
// Each scenario task drives a run and compares {data_out, data_valid, busy, done} every cycle
// against a cycle-indexed reference of the expected waveform.
module tb_seq_pattern_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] pattern = '0;
   logic [3:0] repeat_cnt = '0;
   logic [2:0] gap_cycles = '0;
   logic       data_out, data_valid, busy, done;

   int vectors = 0;
   int errors  = 0;

   seq_pattern_gen #(
      .PAT_W(4),
      .CNT_W(4),
      .GAP_W(3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pattern   (pattern),
      .repeat_cnt(repeat_cnt),
      .gap_cycles(gap_cycles),
      .data_out  (data_out),
      .data_valid(data_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected {data_out, data_valid, busy, done} at cycle cyc after the start edge (cyc 0 is the
   // cycle right after start is sampled).
   function automatic logic [3:0] exp_obs(input logic [3:0] pat, input int rep, input int gap,
                                          input int cyc);
      int total;
      int pos;
      if (rep == 0) return (cyc == 0) ? 4'b0011 : 4'b0000;
      total = rep * 4 + gap * (rep - 1);
      if (cyc < total) begin
         pos = cyc % (4 + gap);
         if (pos < 4) return {pat[3 - pos], 3'b110};
         return 4'b0010;
      end
      if (cyc == total) return 4'b0011;
      return 4'b0000;
   endfunction

   task automatic launch(input logic [3:0] pat, input logic [3:0] rep, input logic [2:0] gap);
      pattern    = pat;
      repeat_cnt = rep;
      gap_cycles = gap;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] obs;
      rst = 1'b1;
      tick();
      tick();
      obs = {data_out, data_valid, busy, done};
      vectors++;
      if (obs !== 4'b0000) begin
         errors++;
         $display("FAIL reset_hold: got %b expected %b", obs, 4'b0000);
      end
      rst = 1'b0;
      tick();
      obs = {data_out, data_valid, busy, done};
      vectors++;
      if (obs !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release: got %b expected %b", obs, 4'b0000);
      end
   endtask

   // Single frame: 0,1,1,0 then done, then idle.
   task automatic test_single_frame();
      logic [3:0] exp_tab [6];
      logic [3:0] obs;
      exp_tab = '{4'b0110, 4'b1110, 4'b1110, 4'b0110, 4'b0011, 4'b0000};
      launch(4'b0110, 4'd1, 3'd0);
      for (int i = 0; i < 6; i++) begin
         obs = {data_out, data_valid, busy, done};
         vectors++;
         if (obs !== exp_tab[i]) begin
            errors++;
            $display("FAIL single_frame cyc %0d: got %b expected %b", i, obs, exp_tab[i]);
         end
         tick();
      end
   endtask

   // Three back-to-back frames; a 0110 detector on the valid stream must fire 3 times.
   task automatic test_back_to_back();
      logic [3:0] obs, exp_v, det;
      int hits;
      det  = '0;
      hits = 0;
      launch(4'b0110, 4'd3, 3'd0);
      for (int i = 0; i < 15; i++) begin
         obs   = {data_out, data_valid, busy, done};
         exp_v = exp_obs(4'b0110, 3, 0, i);
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL back_to_back cyc %0d: got %b expected %b", i, obs, exp_v);
         end
         if (data_valid === 1'b1) begin
            det = {det[2:0], data_out};
            if (det == 4'b0110) hits++;
         end
         tick();
      end
      vectors++;
      if (hits != 3) begin
         errors++;
         $display("FAIL detector_hits: got %0d expected %0d", hits, 3);
      end
   endtask

   task automatic test_gap();
      logic [3:0] obs, exp_v;
      launch(4'b0110, 4'd2, 3'd2);
      for (int i = 0; i < 13; i++) begin
         obs   = {data_out, data_valid, busy, done};
         exp_v = exp_obs(4'b0110, 2, 2, i);
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL gap cyc %0d: got %b expected %b", i, obs, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_zero_repeat();
      logic [3:0] obs, exp_v;
      launch(4'b1011, 4'd0, 3'd3);
      for (int i = 0; i < 4; i++) begin
         obs   = {data_out, data_valid, busy, done};
         exp_v = exp_obs(4'b1011, 0, 3, i);
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL zero_repeat cyc %0d: got %b expected %b", i, obs, exp_v);
         end
         tick();
      end
   endtask

   // start and new inputs while busy must not disturb the captured run.
   task automatic test_start_while_busy();
      logic [3:0] obs, exp_v;
      launch(4'b0110, 4'd2, 3'd1);
      for (int i = 0; i < 12; i++) begin
         obs   = {data_out, data_valid, busy, done};
         exp_v = exp_obs(4'b0110, 2, 1, i);
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL start_while_busy cyc %0d: got %b expected %b", i, obs, exp_v);
         end
         if (i == 1) begin
            pattern    = 4'b1111;
            repeat_cnt = 4'd5;
            gap_cycles = 3'd0;
            start      = 1'b1;
         end
         if (i == 4) start = 1'b0;
         tick();
      end
   endtask

   task automatic test_reset_abort();
      logic [3:0] obs, exp_v;
      launch(4'b0110, 4'd3, 3'd0);
      for (int i = 0; i < 2; i++) begin
         obs   = {data_out, data_valid, busy, done};
         exp_v = exp_obs(4'b0110, 3, 0, i);
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL abort_pre cyc %0d: got %b expected %b", i, obs, exp_v);
         end
         if (i < 1) tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         obs = {data_out, data_valid, busy, done};
         vectors++;
         if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL abort_quiet cyc %0d: got %b expected %b", i, obs, 4'b0000);
         end
         tick();
      end
      launch(4'b1011, 4'd2, 3'd0);
      for (int i = 0; i < 10; i++) begin
         obs   = {data_out, data_valid, busy, done};
         exp_v = exp_obs(4'b1011, 2, 0, i);
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL abort_rerun cyc %0d: got %b expected %b", i, obs, exp_v);
         end
         tick();
      end
   endtask

   // start held high through done: exactly one idle cycle before the second run.
   task automatic test_start_held();
      logic [3:0] obs, exp_v;
      pattern    = 4'b1001;
      repeat_cnt = 4'd1;
      gap_cycles = 3'd0;
      start      = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) begin
         obs   = {data_out, data_valid, busy, done};
         exp_v = (i < 6) ? exp_obs(4'b1001, 1, 0, i) : exp_obs(4'b1001, 1, 0, i - 6);
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL start_held cyc %0d: got %b expected %b", i, obs, exp_v);
         end
         if (i == 7) start = 1'b0;
         tick();
      end
   endtask

   task automatic test_max_repeat();
      logic [3:0] obs, exp_v;
      int n_valid;
      n_valid = 0;
      launch(4'b1010, 4'd15, 3'd1);
      for (int i = 0; i < 76; i++) begin
         obs   = {data_out, data_valid, busy, done};
         exp_v = exp_obs(4'b1010, 15, 1, i);
         vectors++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL max_repeat cyc %0d: got %b expected %b", i, obs, exp_v);
         end
         if (data_valid === 1'b1) n_valid++;
         tick();
      end
      vectors++;
      if (n_valid != 60) begin
         errors++;
         $display("FAIL max_repeat_valid_count: got %0d expected %0d", n_valid, 60);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gap();
      test_zero_repeat();
      test_start_while_busy();
      test_reset_abort();
      test_start_held();
      test_max_repeat();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
